// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: first-word fall-through read, sticky overflow, saturating error count.
// Define UART_RX_FIFO_ERR_DROP_EN to discard frames flagged with a stop-bit error instead of storing them.
module uart_rx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_rx_dv,
   input  logic [7:0]               i_rx_byte,
   input  logic                     i_rx_error,
   input  logic                     i_rd_en,
   input  logic                     i_clr_ovf,
   output logic [7:0]               o_rd_data,
   output logic                     o_rd_valid,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow,
   output logic [7:0]               o_err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    err_cnt_q, err_cnt_d;

   logic full, empty, wr_req, wr_acc, rd_acc, ovf_set;

`ifdef UART_RX_FIFO_ERR_DROP_EN
   assign wr_req = i_rx_dv & ~i_rx_error;
`else
   assign wr_req = i_rx_dv;
`endif

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign rd_acc  = i_rd_en & ~empty;
   // A full FIFO still takes a byte when the same edge pops the head.
   assign wr_acc  = wr_req & (~full | rd_acc);
   assign ovf_set = wr_req & full & ~rd_acc;

   // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      err_cnt_d = err_cnt_q;

      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A new overflow wins over a coincident clear.
      if (ovf_set)        ovf_d = 1'b1;
      else if (i_clr_ovf) ovf_d = 1'b0;

      if (i_rx_dv && i_rx_error && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // NOTE: storage is deliberately left out of reset; count and pointers alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= i_rx_byte;
   end

   assign o_rd_data  = mem_q[rd_ptr_q];
   assign o_rd_valid = ~empty;
   assign o_full     = full;
   assign o_count    = count_q;
   assign o_overflow = ovf_q;
   assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16); runs in either UART_RX_FIFO_ERR_DROP_EN build.
module tb_uart_rx_fifo;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_rx_dv = 1'b0;
   logic [7:0] i_rx_byte = 8'h00;
   logic       i_rx_error = 1'b0;
   logic       i_rd_en = 1'b0;
   logic       i_clr_ovf = 1'b0;
   logic [7:0] o_rd_data;
   logic       o_rd_valid;
   logic       o_full;
   logic [4:0] o_count;
   logic       o_overflow;
   logic [7:0] o_err_cnt;

   int errors = 0;
   int checks = 0;

   uart_rx_fifo #(.DEPTH(16)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rx_dv    (i_rx_dv),
      .i_rx_byte  (i_rx_byte),
      .i_rx_error (i_rx_error),
      .i_rd_en    (i_rd_en),
      .i_clr_ovf  (i_clr_ovf),
      .o_rd_data  (o_rd_data),
      .o_rd_valid (o_rd_valid),
      .o_full     (o_full),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .o_err_cnt  (o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Drive one cycle of inputs, take the rising edge, then settle 1 ns past it.
   task automatic step(input logic dv, input logic [7:0] b, input logic er,
                       input logic rd, input logic clr);
      i_rx_dv = dv; i_rx_byte = b; i_rx_error = er; i_rd_en = rd; i_clr_ovf = clr;
      @(posedge i_clk);
      #1;
      i_rx_dv = 1'b0; i_rx_error = 1'b0; i_rd_en = 1'b0; i_clr_ovf = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      if ({o_rd_valid, o_full, o_count, o_overflow, o_err_cnt} !== 16'h0) begin
         errors++; $display("FAIL reset_outputs got valid=%b full=%b count=%0d ovf=%b err=%0d expected all 0",
                            o_rd_valid, o_full, o_count, o_overflow, o_err_cnt);
      end
      checks++;
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_basic();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
      for (int i = 0; i < 3; i++) step(1'b1, exp_b[i], 1'b0, 1'b0, 1'b0);
      if (o_count !== 5'd3) begin
         errors++; $display("FAIL basic_count got %0d expected 3", o_count);
      end
      checks++;
      for (int i = 0; i < 3; i++) begin
         if (o_rd_valid !== 1'b1 || o_rd_data !== exp_b[i]) begin
            errors++; $display("FAIL basic_pop%0d got valid=%b data=%h expected 1/%h",
                               i, o_rd_valid, o_rd_data, exp_b[i]);
         end
         checks++;
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      if (o_rd_valid !== 1'b0 || o_count !== 5'd0) begin
         errors++; $display("FAIL basic_empty got valid=%b count=%0d expected 0/0", o_rd_valid, o_count);
      end
      checks++;
   endtask

   task automatic test_empty_read();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (o_rd_valid !== 1'b0 || o_count !== 5'd0) begin
         errors++; $display("FAIL empty_read got valid=%b count=%0d expected 0/0", o_rd_valid, o_count);
      end
      checks++;
      step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
      if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h7E || o_count !== 5'd1) begin
         errors++; $display("FAIL empty_read_then_write got valid=%b data=%h count=%0d expected 1/7e/1",
                            o_rd_valid, o_rd_data, o_count);
      end
      checks++;
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_full_overflow();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (o_full !== 1'b1 || o_count !== 5'd16 || o_overflow !== 1'b0) begin
         errors++; $display("FAIL full_flag got full=%b count=%0d ovf=%b expected 1/16/0",
                            o_full, o_count, o_overflow);
      end
      checks++;
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      if (o_overflow !== 1'b1 || o_count !== 5'd16 || o_rd_data !== 8'h00) begin
         errors++; $display("FAIL overflow_set got ovf=%b count=%0d head=%h expected 1/16/00",
                            o_overflow, o_count, o_rd_data);
      end
      checks++;
      step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
      if (o_overflow !== 1'b1) begin
         errors++; $display("FAIL overflow_clr_collision got %b expected 1", o_overflow);
      end
      checks++;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      if (o_overflow !== 1'b0) begin
         errors++; $display("FAIL overflow_clear got %b expected 0", o_overflow);
      end
      checks++;
      for (int i = 0; i < 16; i++) begin
         if (o_rd_data !== 8'(i)) begin
            errors++; $display("FAIL full_pop%0d got %h expected %h", i, o_rd_data, 8'(i));
         end
         checks++;
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      if (o_rd_valid !== 1'b0 || o_full !== 1'b0) begin
         errors++; $display("FAIL full_drained got valid=%b full=%b expected 0/0", o_rd_valid, o_full);
      end
      checks++;
   endtask

   task automatic test_back_to_back_full();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
      if (o_count !== 5'd16 || o_overflow !== 1'b0 || o_rd_data !== 8'h01) begin
         errors++; $display("FAIL full_wr_rd got count=%0d ovf=%b head=%h expected 16/0/01",
                            o_count, o_overflow, o_rd_data);
      end
      checks++;
      for (int i = 1; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (o_count !== 5'd1 || o_rd_data !== 8'h5A) begin
         errors++; $display("FAIL full_wr_rd_last got count=%0d data=%h expected 1/5a", o_count, o_rd_data);
      end
      checks++;
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_error();
      step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
      if (o_err_cnt !== 8'd1 || o_count !== 5'd0) begin
         errors++; $display("FAIL err_drop got err=%0d count=%0d expected 1/0", o_err_cnt, o_count);
      end
`else
      if (o_err_cnt !== 8'd1 || o_count !== 5'd1 || o_rd_data !== 8'hC3) begin
         errors++; $display("FAIL err_keep got err=%0d count=%0d data=%h expected 1/1/c3",
                            o_err_cnt, o_count, o_rd_data);
      end
`endif
      checks++;
      pulse_reset();
      for (int i = 0; i < 255; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      if (o_err_cnt !== 8'd255) begin
         errors++; $display("FAIL err_cnt_255 got %0d expected 255", o_err_cnt);
      end
      checks++;
      for (int i = 255; i < 300; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
      if (o_err_cnt !== 8'd255 || o_count !== 5'd0 || o_overflow !== 1'b0) begin
         errors++; $display("FAIL err_sat got err=%0d count=%0d ovf=%b expected 255/0/0",
                            o_err_cnt, o_count, o_overflow);
      end
`else
      if (o_err_cnt !== 8'd255 || o_count !== 5'd16 || o_overflow !== 1'b1) begin
         errors++; $display("FAIL err_sat got err=%0d count=%0d ovf=%b expected 255/16/1",
                            o_err_cnt, o_count, o_overflow);
      end
`endif
      checks++;
      pulse_reset();
   endtask

   task automatic test_wrap();
      logic [7:0] q[$];
      logic [7:0] b;
      for (int i = 0; i < 40; i++) begin
         b = 8'(i * 7 + 3);
         if (i >= 3) begin
            if (o_rd_data !== q[0]) begin
               errors++; $display("FAIL wrap_pop%0d got %h expected %h", i, o_rd_data, q[0]);
            end
            checks++;
            void'(q.pop_front());
         end
         q.push_back(b);
         step(1'b1, b, 1'b0, (i >= 3), 1'b0);
      end
      if (o_count !== 5'd3) begin
         errors++; $display("FAIL wrap_count got %0d expected 3", o_count);
      end
      checks++;
      for (int i = 0; i < 3; i++) begin
         if (o_rd_data !== q[0]) begin
            errors++; $display("FAIL wrap_drain%0d got %h expected %h", i, o_rd_data, q[0]);
         end
         checks++;
         void'(q.pop_front());
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0, 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      if ({o_rd_valid, o_full, o_count, o_overflow, o_err_cnt} !== 16'h0) begin
         errors++; $display("FAIL async_reset got valid=%b count=%0d err=%0d expected 0/0/0",
                            o_rd_valid, o_count, o_err_cnt);
      end
      checks++;
      // Release reset on the same edge that carries a strobe; the strobe must be ignored.
      i_rx_dv = 1'b1; i_rx_byte = 8'hEE; i_rx_error = 1'b1;
      @(posedge i_clk);
      i_rst <= 1'b0;
      #1;
      i_rx_dv = 1'b0; i_rx_error = 1'b0;
      if (o_count !== 5'd0 || o_err_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_release_strobe got count=%0d err=%0d expected 0/0", o_count, o_err_cnt);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_read();
      test_full_overflow();
      test_back_to_back_full();
      test_error();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
